// File: rtl/sync_fifo_flags.sv
// ---------------------------------------------------------------------------
// sync_fifo_flags
//
// Single-clock FIFO for streaming datapaths. It provides an occupancy count,
// programmable almost-full / almost-empty thresholds, and sticky overflow /
// underflow error flags. The FWFT parameter selects the read mode:
//   FWFT=1 : the head word is always on dout while the FIFO is not empty.
//   FWFT=0 : dout is a register loaded by an accepted read; it is valid for
//            one cycle, the cycle after the read.
//
// Parameters
//   WIDTH      data width (>=1)
//   DEPTH      number of entries (power of two, >=2)
//   FWFT       1 = first-word-fall-through, 0 = registered read
//   AF_THRESH  almost_full  when count >= AF_THRESH (1..DEPTH)
//   AE_THRESH  almost_empty when count <= AE_THRESH (0..DEPTH-1)
//
// Ports
//   clk           clock; all logic on the rising edge
//   rst           synchronous active-high reset
//   wr, din       write request and data
//   full          count == DEPTH
//   rd            read request (pop)
//   dout, dvld    read data and its valid
//   empty         count == 0
//   count         words stored ($clog2(DEPTH)+1 bits)
//   almost_full   count >= AF_THRESH
//   almost_empty  count <= AE_THRESH
//   overflow      sticky: write attempted while full
//   underflow     sticky: read attempted while empty
//   clr_err       clears overflow and underflow (a same-cycle set wins)
// ---------------------------------------------------------------------------
module sync_fifo_flags #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 8,
  parameter int FWFT      = 1,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr,
  input  logic [WIDTH-1:0]           din,
  output logic                       full,
  input  logic                       rd,
  output logic [WIDTH-1:0]           dout,
  output logic                       dvld,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic                       overflow,
  output logic                       underflow,
  input  logic                       clr_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  logic             wr_acc;
  logic             rd_acc;

  // All flags decode the registered count, so they always agree with it.
  assign count        = count_q;
  assign full         = (count_q == DEPTH_C);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);

  // Acceptance looks only at this cycle's flags: a simultaneous read never
  // makes room for a write when full, and a simultaneous write never feeds
  // a read when empty.
  assign wr_acc = wr & ~full;
  assign rd_acc = rd & ~empty;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_q   <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;

      case ({wr_acc, rd_acc})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase

      // Set term is OR-ed after the clear so a same-cycle event survives.
      overflow  <= (wr & full)  | (overflow  & ~clr_err);
      underflow <= (rd & empty) | (underflow & ~clr_err);
    end
  end

  // NOTE: the storage array has no reset; stale contents are unreachable
  // because the pointers and count are reset, and leaving it unreset lets
  // it map onto plain RAM.
  always_ff @(posedge clk) begin
    if (wr_acc && !rst) mem[wr_ptr] <= din;
  end

  if (FWFT != 0) begin : g_fwft
    // Head entry shown combinationally; forced to zero while empty so the
    // output is defined (and zero) after reset.
    assign dout = empty ? '0 : mem[rd_ptr];
    assign dvld = ~empty;
  end else begin : g_std
    logic [WIDTH-1:0] dout_q;
    logic             dvld_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        dout_q <= '0;
        dvld_q <= 1'b0;
      end else begin
        dvld_q <= rd_acc;
        if (rd_acc) dout_q <= mem[rd_ptr];
      end
    end

    assign dout = dout_q;
    assign dvld = dvld_q;
  end

endmodule

// File: tb/tb_sync_fifo_flags.sv
// ---------------------------------------------------------------------------
// tb_sync_fifo_flags
//
// Three instances:
//   a : DEPTH=8,  WIDTH=32, FWFT=1, AF=6,  AE=2
//   b : DEPTH=8,  WIDTH=32, FWFT=0, AF=6,  AE=2   (same inputs as a)
//   c : DEPTH=16, WIDTH=8,  FWFT=0, AF=16, AE=0   (own random stream)
// Reference model: a queue of stored words plus sticky error bits, updated
// from the acceptance rules. Expected read words are pushed into per-DUT
// queues; monitors pop them whenever a DUT presents a word.
// Inputs change 1 ns after the rising edge; state is compared on the
// falling edge, read data 1 ns after the falling edge.
// ---------------------------------------------------------------------------
module tb_sync_fifo_flags;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- shared stimulus for a/b ----------------
  logic        rst = 1'b1, wr = 1'b0, rd = 1'b0, clr = 1'b0;
  logic [31:0] din = '0;

  logic [31:0] a_dout, b_dout;
  logic [3:0]  a_count, b_count;
  logic a_full, a_empty, a_dvld, a_af, a_ae, a_ovf, a_unf;
  logic b_full, b_empty, b_dvld, b_af, b_ae, b_ovf, b_unf;

  sync_fifo_flags #(.WIDTH(32), .DEPTH(8), .FWFT(1), .AF_THRESH(6), .AE_THRESH(2)) u_a (
    .clk(clk), .rst(rst), .wr(wr), .din(din), .full(a_full), .rd(rd),
    .dout(a_dout), .dvld(a_dvld), .empty(a_empty), .count(a_count),
    .almost_full(a_af), .almost_empty(a_ae), .overflow(a_ovf),
    .underflow(a_unf), .clr_err(clr));

  sync_fifo_flags #(.WIDTH(32), .DEPTH(8), .FWFT(0), .AF_THRESH(6), .AE_THRESH(2)) u_b (
    .clk(clk), .rst(rst), .wr(wr), .din(din), .full(b_full), .rd(rd),
    .dout(b_dout), .dvld(b_dvld), .empty(b_empty), .count(b_count),
    .almost_full(b_af), .almost_empty(b_ae), .overflow(b_ovf),
    .underflow(b_unf), .clr_err(clr));

  // ---------------- independent stimulus for c ----------------
  logic       c_rst = 1'b1, c_wr = 1'b0, c_rd = 1'b0, c_clr = 1'b0;
  logic [7:0] c_din = '0;
  logic [7:0] c_dout;
  logic [4:0] c_count;
  logic c_full, c_empty, c_dvld, c_af, c_ae, c_ovf, c_unf;

  sync_fifo_flags #(.WIDTH(8), .DEPTH(16), .FWFT(0), .AF_THRESH(16), .AE_THRESH(0)) u_c (
    .clk(clk), .rst(c_rst), .wr(c_wr), .din(c_din), .full(c_full), .rd(c_rd),
    .dout(c_dout), .dvld(c_dvld), .empty(c_empty), .count(c_count),
    .almost_full(c_af), .almost_empty(c_ae), .overflow(c_ovf),
    .underflow(c_unf), .clr_err(c_clr));

  // ---------------- reference model for a/b ----------------
  logic [31:0] q_ab[$];
  logic [31:0] exp_a[$];
  logic [31:0] exp_b[$];
  bit m_ovf_ab = 0, m_unf_ab = 0, m_rdv_ab = 0;

  always @(negedge clk) begin : model_ab
    int n;
    bit full_m, empty_m, racc, wacc;
    n = q_ab.size();
    check("a_count", a_count, n);
    check("a_full",  a_full,  n == 8);
    check("a_empty", a_empty, n == 0);
    check("a_af",    a_af,    n >= 6);
    check("a_ae",    a_ae,    n <= 2);
    check("a_ovf",   a_ovf,   m_ovf_ab);
    check("a_unf",   a_unf,   m_unf_ab);
    check("a_dvld",  a_dvld,  n != 0);
    check("b_count", b_count, n);
    check("b_full",  b_full,  n == 8);
    check("b_empty", b_empty, n == 0);
    check("b_af",    b_af,    n >= 6);
    check("b_ae",    b_ae,    n <= 2);
    check("b_ovf",   b_ovf,   m_ovf_ab);
    check("b_unf",   b_unf,   m_unf_ab);
    check("b_dvld",  b_dvld,  m_rdv_ab);
    // Advance the model across the coming rising edge.
    if (rst) begin
      q_ab.delete();
      m_ovf_ab = 0; m_unf_ab = 0; m_rdv_ab = 0;
    end else begin
      full_m  = (n == 8);
      empty_m = (n == 0);
      wacc = wr && !full_m;
      racc = rd && !empty_m;
      if (racc) begin
        exp_a.push_back(q_ab[0]);
        exp_b.push_back(q_ab[0]);
        void'(q_ab.pop_front());
      end
      if (wacc) q_ab.push_back(din);
      m_ovf_ab = (wr && full_m)  || (m_ovf_ab && !clr);
      m_unf_ab = (rd && empty_m) || (m_unf_ab && !clr);
      m_rdv_ab = racc;
    end
  end

  // ---------------- reference model for c ----------------
  logic [7:0] q_c[$];
  logic [7:0] exp_c[$];
  bit m_ovf_c = 0, m_unf_c = 0, m_rdv_c = 0;

  always @(negedge clk) begin : model_c
    int n;
    bit full_m, empty_m, racc, wacc;
    n = q_c.size();
    check("c_count", c_count, n);
    check("c_full",  c_full,  n == 16);
    check("c_empty", c_empty, n == 0);
    check("c_af",    c_af,    n >= 16);
    check("c_ae",    c_ae,    n <= 0);
    check("c_ovf",   c_ovf,   m_ovf_c);
    check("c_unf",   c_unf,   m_unf_c);
    check("c_dvld",  c_dvld,  m_rdv_c);
    if (c_rst) begin
      q_c.delete();
      m_ovf_c = 0; m_unf_c = 0; m_rdv_c = 0;
    end else begin
      full_m  = (n == 16);
      empty_m = (n == 0);
      wacc = c_wr && !full_m;
      racc = c_rd && !empty_m;
      if (racc) begin
        exp_c.push_back(q_c[0]);
        void'(q_c.pop_front());
      end
      if (wacc) q_c.push_back(c_din);
      m_ovf_c = (c_wr && full_m)  || (m_ovf_c && !c_clr);
      m_unf_c = (c_rd && empty_m) || (m_unf_c && !c_clr);
      m_rdv_c = racc;
    end
  end

  // ---------------- monitors ----------------
  always @(negedge clk) begin : mon_a
    #1;
    if (!rst && rd && a_dvld) begin
      check("a_exp_avail", exp_a.size() != 0, 1'b1);
      if (exp_a.size() != 0) check("a_data", a_dout, exp_a.pop_front());
    end
  end

  always @(negedge clk) begin : mon_b
    #1;
    if (b_dvld) begin
      check("b_exp_avail", exp_b.size() != 0, 1'b1);
      if (exp_b.size() != 0) check("b_data", b_dout, exp_b.pop_front());
    end
  end

  always @(negedge clk) begin : mon_c
    #1;
    if (c_dvld) begin
      check("c_exp_avail", exp_c.size() != 0, 1'b1);
      if (exp_c.size() != 0) check("c_data", c_dout, exp_c.pop_front());
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic ab_cyc(input bit w, input bit r, input logic [31:0] d, input bit c, input bit rs);
    wr = w; rd = r; din = d; clr = c; rst = rs;
    @(posedge clk); #1;
  endtask

  task automatic c_cyc(input bit w, input bit r, input logic [7:0] d, input bit c, input bit rs);
    c_wr = w; c_rd = r; c_din = d; c_clr = c; c_rst = rs;
    @(posedge clk); #1;
  endtask

  task automatic ab_sequence();
    // Reset and reset-value check of the data outputs.
    ab_cyc(0, 0, 0, 0, 1);
    ab_cyc(0, 0, 0, 0, 1);
    ab_cyc(0, 0, 0, 0, 0);
    check("a_dout_rst", a_dout, 0);
    check("b_dout_rst", b_dout, 0);

    // Fill 0..7 then overflow attempt then clear, then drain.
    for (int i = 0; i < 8; i++) ab_cyc(1, 0, i, 0, 0);
    ab_cyc(1, 0, 32'hDEADBEEF, 0, 0);
    ab_cyc(0, 0, 0, 1, 0);
    ab_cyc(0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) ab_cyc(0, 1, 0, 0, 0);
    ab_cyc(0, 0, 0, 0, 0);

    // Simultaneous wr+rd at full: read accepted, write dropped, overflow.
    for (int i = 0; i < 8; i++) ab_cyc(1, 0, 100 + i, 0, 0);
    ab_cyc(1, 1, 32'hAAAA_AAAA, 0, 0);
    for (int i = 0; i < 7; i++) ab_cyc(0, 1, 0, 0, 0);
    // Simultaneous wr+rd at empty: write accepted, underflow.
    ab_cyc(1, 1, 32'h0000_0055, 0, 0);
    ab_cyc(0, 0, 0, 1, 0);
    // Simultaneous wr+rd at count 4: both accepted.
    for (int i = 0; i < 3; i++) ab_cyc(1, 0, 200 + i, 0, 0);
    ab_cyc(1, 1, 32'h0000_0077, 0, 0);
    for (int i = 0; i < 4; i++) ab_cyc(0, 1, 0, 0, 0);
    ab_cyc(0, 0, 0, 0, 0);

    // Reset mid-stream with 5 words stored and wr=rd=1.
    for (int i = 0; i < 5; i++) ab_cyc(1, 0, 300 + i, 0, 0);
    ab_cyc(1, 1, 32'h99, 0, 1);
    check("a_dout_midrst", a_dout, 0);
    check("b_dout_midrst", b_dout, 0);
    ab_cyc(1, 0, 32'h1234_5678, 0, 0);
    ab_cyc(0, 1, 0, 0, 0);
    ab_cyc(0, 0, 0, 0, 0);

    // Random soak with changing write/read probabilities.
    for (int blk = 0; blk < 10; blk++) begin
      int pw, pr;
      pw = $urandom_range(90, 10);
      pr = $urandom_range(90, 10);
      for (int k = 0; k < 1000; k++)
        ab_cyc($urandom_range(99, 0) < pw, $urandom_range(99, 0) < pr, $urandom,
               $urandom_range(49, 0) == 0, $urandom_range(999, 0) == 0);
    end
    ab_cyc(0, 0, 0, 0, 0);
  endtask

  task automatic c_sequence();
    c_cyc(0, 0, 0, 0, 1);
    c_cyc(0, 0, 0, 0, 1);
    for (int blk = 0; blk < 10; blk++) begin
      int pw, pr;
      pw = $urandom_range(90, 10);
      pr = $urandom_range(90, 10);
      for (int k = 0; k < 1000; k++)
        c_cyc($urandom_range(99, 0) < pw, $urandom_range(99, 0) < pr, 8'($urandom),
              $urandom_range(49, 0) == 0, $urandom_range(699, 0) == 0);
    end
    c_cyc(0, 0, 0, 0, 0);
  endtask

  initial begin
    fork
      ab_sequence();
      c_sequence();
    join
    repeat (3) @(posedge clk);
    #1;
    check("a_exp_drained", exp_a.size(), 0);
    check("b_exp_drained", exp_b.size(), 0);
    check("c_exp_drained", exp_c.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
